// File: rtl/replay_control.sv
// rtl/replay_control.sv - error-recovery sequencer: blocks fetch and sweeps every register-file address once per replay
module replay_control #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  error_i,
  output logic [ADDR_WIDTH-1:0] replay_addr_o,
  output logic                  fetch_block_o
);

  localparam int NUM_REG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REG - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   count, count_next;
  logic                    block, block_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      block <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      block <= block_next;
    end
  end

  // Any error, even on the final address, restarts the sweep from zero.
  always_comb begin
    state_next = state;
    count_next = '0;
    block_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (error_i) begin
          state_next = REPLAY;
          block_next = 1'b1;
        end
      end
      REPLAY: begin
        if (error_i) begin
          block_next = 1'b1;
        end else if (count == LAST_ADDR) begin
          state_next = IDLE;
        end else begin
          count_next = count + 1'b1;
          block_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign replay_addr_o = count;
  assign fetch_block_o = block;

endmodule

// File: tb/tb_replay_control.sv
// tb/tb_replay_control.sv - scoreboard bench for replay_control with directed, hand-sequenced vectors
module tb_replay_control;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          error_i = 1'b0;
  logic [AW-1:0] replay_addr_o;
  logic          fetch_block_o;

  int n_vec = 0;
  int n_miss = 0;

  // Each entry is {fetch_block, addr} expected just after the next rising edge.
  logic [AW:0] exp_q[$];

  replay_control #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .error_i       (error_i),
    .replay_addr_o (replay_addr_o),
    .fetch_block_o (fetch_block_o)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic err, input logic efb, input int eaddr);
    @(negedge clk);
    reset   = rst;
    error_i = err;
    exp_q.push_back({efb, AW'(eaddr)});
  endtask

  // Single error pulse followed by an uninterrupted sweep and the drop back to idle.
  task automatic full_sweep();
    step(0, 1, 1, 0);
    for (int i = 1; i < 32; i++) step(0, 0, 1, i);
    step(0, 0, 0, 0);
  endtask

  initial begin : monitor
    logic [AW:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (fetch_block_o !== e[AW] || replay_addr_o !== e[AW-1:0]) begin
          n_miss++;
          $display("FAIL vec%0d: fetch_block=%b addr=%0d, required fetch_block=%b addr=%0d",
                   n_vec, fetch_block_o, replay_addr_o, e[AW], e[AW-1:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset then quiet idle.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);

    // One pulse, full sweep.
    full_sweep();
    step(0, 0, 0, 0);

    // Two pulses 34 cycles apart.
    full_sweep();
    step(0, 0, 0, 0);
    full_sweep();
    step(0, 0, 0, 0);

    // Restart at address 10.
    step(0, 1, 1, 0);
    for (int i = 1; i <= 10; i++) step(0, 0, 1, i);
    step(0, 1, 1, 0);
    for (int i = 1; i < 32; i++) step(0, 0, 1, i);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Restart on the final address.
    step(0, 1, 1, 0);
    for (int i = 1; i < 32; i++) step(0, 0, 1, i);
    step(0, 1, 1, 0);
    for (int i = 1; i < 32; i++) step(0, 0, 1, i);
    step(0, 0, 0, 0);

    // New error on the cycle right after a sweep ends; error held 5 cycles.
    step(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    for (int i = 1; i < 32; i++) step(0, 0, 1, i);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset with error at address 15 wins, then a clean sweep.
    step(0, 1, 1, 0);
    for (int i = 1; i <= 15; i++) step(0, 0, 1, i);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    full_sweep();
    step(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
